// File: rtl/and2t_pulse_sequencer.sv
// Request/response controller for one clocked RSFQ AND2T cell using toggle-encoded pulses.
// Optional self-check: define AND2T_SEQ_CHECK_EN to enable the sticky err flag.
module and2t_pulse_sequencer #(
    parameter int SEP_CYCLES    = 4,
    parameter int Q_WAIT_CYCLES = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_a,
    input  logic req_b,
    output logic req_ready,
    output logic a_out,
    output logic b_out,
    output logic cell_clk_out,
    input  logic q_in,
    output logic rsp_valid,
    output logic rsp_data,
    input  logic rsp_ready,
    output logic err
);

    typedef enum logic [1:0] {
        IDLE,
        SEP,
        WAIT,
        RESP
    } state_t;

    localparam logic [7:0] SEP_LOAD  = 8'(SEP_CYCLES - 1);
    localparam logic [7:0] WAIT_LOAD = 8'(Q_WAIT_CYCLES - 1);

    generate
        if (SEP_CYCLES < 1 || SEP_CYCLES > 255) begin : g_bad_sep
            $error("and2t_pulse_sequencer: SEP_CYCLES must be in 1..255");
        end
        if (Q_WAIT_CYCLES < 1 || Q_WAIT_CYCLES > 255) begin : g_bad_wait
            $error("and2t_pulse_sequencer: Q_WAIT_CYCLES must be in 1..255");
        end
    endgenerate

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] tog_q, tog_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       cclk_q, cclk_d;
    logic       q_ref_q, q_ref_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_data_q, rsp_data_d;

    logic       q_chg;
    logic [1:0] tog_sample;

    // The toggle count includes the current cycle's q_in sample and saturates at 2.
    always_comb begin
        q_chg      = q_in ^ q_ref_q;
        tog_sample = tog_q;
        if (q_chg && (tog_q != 2'd2)) begin
            tog_sample = tog_q + 2'd1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tog_d       = tog_q;
        a_d         = a_q;
        b_d         = b_q;
        cclk_d      = cclk_q;
        q_ref_d     = q_in;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    a_d     = a_q ^ req_a;
                    b_d     = b_q ^ req_b;
                    cnt_d   = SEP_LOAD;
                    state_d = SEP;
                end
            end
            SEP: begin
                if (cnt_q == 8'd0) begin
                    cclk_d  = ~cclk_q;
                    cnt_d   = WAIT_LOAD;
                    tog_d   = 2'd0;
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT: begin
                tog_d = tog_sample;
                if (cnt_q == 8'd0) begin
                    rsp_data_d  = (tog_sample != 2'd0);
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            tog_q       <= 2'd0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            cclk_q      <= 1'b0;
            q_ref_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tog_q       <= tog_d;
            a_q         <= a_d;
            b_q         <= b_d;
            cclk_q      <= cclk_d;
            q_ref_q     <= q_ref_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

`ifdef AND2T_SEQ_CHECK_EN
    logic exp_q, exp_d;
    logic err_q, err_d;

    // err flags a wrong result, a double toggle in one window, or q activity outside a window.
    always_comb begin
        exp_d = exp_q;
        err_d = err_q;
        if ((state_q == IDLE) && req_valid) begin
            exp_d = req_a & req_b;
        end
        if (state_q == WAIT) begin
            if (tog_sample == 2'd2) begin
                err_d = 1'b1;
            end
            if ((cnt_q == 8'd0) && ((tog_sample != 2'd0) != exp_q)) begin
                err_d = 1'b1;
            end
        end else if (q_chg) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            exp_q <= exp_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign req_ready    = (state_q == IDLE);
    assign a_out        = a_q;
    assign b_out        = b_q;
    assign cell_clk_out = cclk_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;

endmodule

// File: tb/tb_and2t_pulse_sequencer.sv
// Randomized self-checking bench for and2t_pulse_sequencer with a behavioural AND2T cell model.
// Expected values come from operand arithmetic and the SEP/Q_WAIT timing rules.
module tb_and2t_pulse_sequencer;

    localparam int SEP = 4;
    localparam int QW  = 10;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic req_valid = 1'b0;
    logic req_a     = 1'b0;
    logic req_b     = 1'b0;
    logic rsp_ready = 1'b1;
    logic q_cell    = 1'b0;
    logic q_inj     = 1'b0;
    logic q_in;
    logic req_ready, a_out, b_out, cell_clk_out, rsp_valid, rsp_data, err;

    int   compared    = 0;
    int   mismatched  = 0;
    int   cyc         = 0;
    int   last_accept = 0;
    logic gap_valid   = 1'b0;
    logic a_lvl       = 1'b0;
    logic b_lvl       = 1'b0;
    logic c_lvl       = 1'b0;
    logic exp_err     = 1'b0;

    logic a_prev = 1'b0, b_prev = 1'b0, c_prev = 1'b0;
    logic a_st   = 1'b0, b_st   = 1'b0;
    int   pend   = 0;

    assign q_in = q_cell ^ q_inj;

    and2t_pulse_sequencer #(
        .SEP_CYCLES    (SEP),
        .Q_WAIT_CYCLES (QW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .a_out        (a_out),
        .b_out        (b_out),
        .cell_clk_out (cell_clk_out),
        .q_in         (q_in),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_ready    (rsp_ready),
        .err          (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Cell model: data pulses arm the inputs, a clock pulse with both armed toggles q a little later.
    always @(negedge clk) begin
        if (pend != 0) pend <= pend - 1;
        if (pend == 1) q_cell <= ~q_cell;
        if (cell_clk_out != c_prev) begin
            if (a_st && b_st) pend <= 2;
            a_st <= 1'b0;
            b_st <= 1'b0;
        end else begin
            if (a_out != a_prev) a_st <= 1'b1;
            if (b_out != b_prev) b_st <= 1'b1;
        end
        a_prev <= a_out;
        b_prev <= b_out;
        c_prev <= cell_clk_out;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One full transaction; inj_k is the cycle after accept at which an extra q toggle is forced (0 = none).
    task automatic applyStimulus(input logic a, input logic b, input int hold, input int inj_k,
                                 input logic chk_rsp);
        logic exp_rsp;
        int   waited;
        waited = 0;
        while (!req_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checkOutput("req_ready_wait", {31'd0, req_ready}, 32'd1);
        rsp_ready = (hold == 0);
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (gap_valid) checkOutput("accept_gap", cyc - last_accept, SEP + QW + 2);
        last_accept = cyc;
        a_lvl = a_lvl ^ a;
        b_lvl = b_lvl ^ b;
        exp_rsp = (a & b) | ((inj_k >= SEP) && (inj_k < SEP + QW));
`ifdef AND2T_SEQ_CHECK_EN
        if (inj_k != 0) exp_err = 1'b1;
`endif
        checkOutput("a_at_T0", {31'd0, a_out}, {31'd0, a_lvl});
        checkOutput("b_at_T0", {31'd0, b_out}, {31'd0, b_lvl});
        checkOutput("req_ready_busy", {31'd0, req_ready}, 32'd0);
        for (int k = 1; k <= SEP + QW; k++) begin
            @(posedge clk); #1;
            if (k == inj_k) q_inj = ~q_inj;
            if (k == SEP) c_lvl = ~c_lvl;
            checkOutput("cell_clk", {31'd0, cell_clk_out}, {31'd0, c_lvl});
            checkOutput("a_hold", {31'd0, a_out}, {31'd0, a_lvl});
            checkOutput("b_hold", {31'd0, b_out}, {31'd0, b_lvl});
            checkOutput("rsp_valid_timing", {31'd0, rsp_valid}, {31'd0, (k == SEP + QW)});
        end
        if (chk_rsp) begin
            checkOutput("rsp_data", {31'd0, rsp_data}, {31'd0, exp_rsp});
            checkOutput("err", {31'd0, err}, {31'd0, exp_err});
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checkOutput("hold_valid", {31'd0, rsp_valid}, 32'd1);
            checkOutput("hold_data", {31'd0, rsp_data}, {31'd0, exp_rsp});
            checkOutput("hold_ready", {31'd0, req_ready}, 32'd0);
        end
        if (hold > 0) begin
            rsp_ready = 1'b1;
            req_a     = 1'b1;
            req_b     = 1'b1;
            req_valid = 1'b1;
        end
        @(posedge clk); #1;
        checkOutput("rsp_cleared", {31'd0, rsp_valid}, 32'd0);
        checkOutput("ready_again", {31'd0, req_ready}, 32'd1);
        checkOutput("no_early_accept", {31'd0, a_out}, {31'd0, a_lvl});
        req_valid = 1'b0;
        gap_valid = (hold == 0);
    endtask

    task automatic checkAllClear(input string tag);
        checkOutput({tag, "_a"}, {31'd0, a_out}, 32'd0);
        checkOutput({tag, "_b"}, {31'd0, b_out}, 32'd0);
        checkOutput({tag, "_clk"}, {31'd0, cell_clk_out}, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, rsp_valid}, 32'd0);
        checkOutput({tag, "_data"}, {31'd0, rsp_data}, 32'd0);
        checkOutput({tag, "_err"}, {31'd0, err}, 32'd0);
        checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic ra, rb;
        int   rh;
        #1;
        checkAllClear("reset");
        #11 rst = 1'b0;
        @(posedge clk); #1;

        applyStimulus(1'b1, 1'b1, 0, 0, 1'b1);
        applyStimulus(1'b1, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b0, 1'b1, 0, 0, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);
        applyStimulus(1'b1, 1'b1, 5, 0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            rh = $urandom_range(0, 2);
            applyStimulus(ra, rb, rh, 0, 1'b1);
        end

        applyStimulus(1'b0, 1'b1, 0, 2, 1'b1);
        applyStimulus(1'b1, 1'b1, 0, 2, 1'b1);
        applyStimulus(1'b1, 1'b1, 0, SEP + 5, 1'b1);
        applyStimulus(1'b0, 1'b0, 0, 0, 1'b1);

        req_a     = 1'b1;
        req_b     = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkAllClear("mid_reset");
        a_lvl     = 1'b0;
        b_lvl     = 1'b0;
        c_lvl     = 1'b0;
        exp_err   = 1'b0;
        gap_valid = 1'b0;
        #1 rst = 1'b0;

        applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        if (q_in) q_inj = ~q_inj;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checkAllClear("flush_reset");
        a_lvl     = 1'b0;
        b_lvl     = 1'b0;
        c_lvl     = 1'b0;
        gap_valid = 1'b0;
        #1 rst = 1'b0;
        applyStimulus(1'b1, 1'b1, 0, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
